fifo_file_io: RTL
=================

Name: fifo_file_io

Overview:
- Second-generation bench file-I/O peripheral on the openMSP430 peripheral bus.
- Replaces the single-byte DATA/STATUS pair with a parametrised RX FIFO (host→CPU) and a parametrised TX FIFO (CPU→host).
- Host side is a valid/ready byte stream on each direction, driven by the Verilator harness or a simulation file-reader wrapper.
- Adds sticky error flags, software flush and a level interrupt.

Parameters:
- BASE_ADDR, 15'h00c0, byte base address; aligned to 2^DEC_WD.
- DEC_WD, 3, address decode width; covers offsets 0x0–0x7.
- RX_DEPTH, 16, RX FIFO entries; power of 2, 2..128.
- TX_DEPTH, 16, TX FIFO entries; power of 2, 2..128.

Ports:
- mclk  in  1  clock.
- puc_rst  in  1  asynchronous, active-high reset.
- per_addr  in  14  word address.
- per_din  in  16  write data.
- per_en  in  1  peripheral access enable.
- per_we  in  2  byte write enables; 00 = read.
- per_dout  out  16  read data, combinational; 0 when not selected.
- rx_data  in  8  host byte toward CPU.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  RX FIFO can accept a byte.
- tx_data  out  8  TX FIFO head byte.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  host accepts tx_data.
- irq  out  1  level interrupt.

Behaviour:
- Registers (word access; offsets 0x0 STATUS, 0x2 DATA, 0x4 CTRL; 0x6 reads 0):
  - STATUS[0] rx_nempty.
  - STATUS[1] tx_nfull.
  - STATUS[2] rx_underflow (sticky).
  - STATUS[3] tx_overflow (sticky).
  - STATUS[15:8] rx_count.
  - STATUS write: per_din[2], per_din[3] write-1-to-clear the sticky bits; all other bits read-only.
  - CTRL[0] rx_ie, CTRL[1] tx_ie: read/write.
  - CTRL[2] rx_flush, CTRL[3] tx_flush: self-clearing, read as 0.
- Reset values:
  - All FIFO pointers and counts 0.
  - Sticky bits 0; CTRL 0.
  - rx_ready=1, tx_valid=0, tx_data=0, irq=0.
  - per_dout=0.
- RX push:
  - rx_ready = (rx_count != RX_DEPTH).
  - Push on rx_valid & rx_ready at the mclk edge.
- DATA read:
  - per_dout[7:0] = RX head combinationally in the same cycle; [15:8] = 0.
  - Pop at the end of that cycle.
  - Read when empty: returns 0x0000, no pop, sets rx_underflow.
- DATA write:
  - Any per_we[0] write pushes per_din[7:0] into TX.
  - Write when tx_count == TX_DEPTH (evaluated before the same-cycle pop): byte dropped, tx_overflow set.
- TX pop:
  - tx_valid = (tx_count != 0); tx_data = TX head.
  - Pop on tx_valid & tx_ready.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
- RX full with a same-cycle pop: rx_ready stays 0 (combinational from registered count); no push that cycle.
- Flush: clears pointers and count next edge; wins over a same-cycle push or pop, and the pushed byte is discarded.
- Pointers: log2(DEPTH) bits, natural wrap; count is log2(DEPTH)+1 bits.
- Sticky set and W1C in the same cycle: set wins.
- irq = (rx_ie & rx_nempty) | (tx_ie & (tx_count==0)), registered; 1-cycle latency after the underlying condition changes.
- puc_rst mid-transfer: all state cleared immediately; FIFO storage need not reset, but must never be observable while count==0.
- Byte-only write to the high byte (per_we=10) of DATA: ignored.

Decomposition:
- Shared include fio_defs:
  - Register offsets (STATUS=0, DATA=2, CTRL=4).
  - STATUS bit indices.
  - CTRL bit indices.
- One sub-module fio_fifo (params WIDTH=8, DEPTH):
  - Inputs: push, pop, flush, din.
  - Outputs: dout, count, full, empty.
  - Instantiated twice.
- Top level holds the decoder, STATUS/CTRL, sticky logic and irq.

Test Plan:
- Reset then idle: STATUS reads 0x0002, rx_ready=1, tx_valid=0, irq=0.
- Host pushes 0x41,0x42,0x43 → STATUS[15:8]=3; three DATA reads return 0x0041, 0x0042, 0x0043; fourth read returns 0x0000 with STATUS[2]=1; writing 0x0004 to STATUS clears it.
- With tx_ready=0, CPU writes 17 bytes 0x00..0x10 (TX_DEPTH=16): STATUS[1]=0 and STATUS[3]=1; raising tx_ready drains exactly 0x00..0x0F in order.
- RX fill to 16 with rx_valid held high: rx_ready=0. CPU reads once: rx_ready=1 the next cycle, and the 17th byte is accepted the cycle after that.
- CTRL=0x0001 with RX empty → irq=0; one host push → irq=1 one cycle later. Write CTRL=0x0005 (flush) → count 0, irq=0 next cycle.
- Assert puc_rst mid-stream with 5 bytes in each FIFO → immediately tx_valid=0, rx_count=0, CTRL=0.

Source files
------------

// File: rtl/fifo_file_io_pkg.sv
// Shared definitions for the file-I/O peripheral: register offsets, bit positions
// and the STATUS word packing.
package fifo_file_io_pkg;

   localparam int OFF_STATUS = 0;
   localparam int OFF_DATA   = 2;
   localparam int OFF_CTRL   = 4;

   localparam int ST_RX_NEMPTY  = 0;
   localparam int ST_TX_NFULL   = 1;
   localparam int ST_RX_UNF     = 2;
   localparam int ST_TX_OVF     = 3;
   localparam int ST_RX_CNT_LSB = 8;

   localparam int CT_RX_IE    = 0;
   localparam int CT_TX_IE    = 1;
   localparam int CT_RX_FLUSH = 2;
   localparam int CT_TX_FLUSH = 3;

   typedef struct packed {
      logic tx_ovf;
      logic rx_unf;
   } sticky_t;

   typedef struct packed {
      logic tx_ie;
      logic rx_ie;
   } ctrl_t;

   function automatic logic [15:0] pack_status(input logic [7:0] rx_cnt,
                                               input sticky_t    st,
                                               input logic       tx_nfull,
                                               input logic       rx_nempty);
      logic [15:0] w;
      w = '0;
      w[ST_RX_CNT_LSB +: 8] = rx_cnt;
      w[ST_TX_OVF]          = st.tx_ovf;
      w[ST_RX_UNF]          = st.rx_unf;
      w[ST_TX_NFULL]        = tx_nfull;
      w[ST_RX_NEMPTY]       = rx_nempty;
      return w;
   endfunction

endpackage

// File: rtl/fifo_file_io_if.sv
// Peripheral bus plus host byte streams of the file-I/O block.
interface fifo_file_io_if;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output per_addr, per_din, per_en, per_we, rx_data, rx_valid, tx_ready,
      input  per_dout, rx_ready, tx_data, tx_valid
   );

   modport slave (
      input  per_addr, per_din, per_en, per_we, rx_data, rx_valid, tx_ready,
      output per_dout, rx_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/fifo_file_io_fifo.sv
// Synchronous FIFO with flush; head reads as zero whenever the FIFO is empty so
// stale storage is never visible.
module fio_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fifo_file_io.sv
// Bench file-I/O peripheral: register decode, STATUS/CTRL, sticky errors, irq,
// and the RX (host to CPU) / TX (CPU to host) FIFOs.
module fifo_file_io
   import fifo_file_io_pkg::*;
#(
   parameter logic [14:0] BASE_ADDR = 15'h00c0,
   parameter int          DEC_WD    = 3,
   parameter int          RX_DEPTH  = 16,
   parameter int          TX_DEPTH  = 16
) (
   input  logic          mclk,
   input  logic          puc_rst,
   fifo_file_io_if.slave bus,
   output logic          irq
);

   localparam int RX_CW = $clog2(RX_DEPTH) + 1;
   localparam int TX_CW = $clog2(TX_DEPTH) + 1;

   logic              reg_sel;
   logic [DEC_WD-1:0] reg_addr;
   logic              rd;
   logic              wr_lo;
   logic              sel_status;
   logic              sel_data;
   logic              sel_ctrl;

   assign reg_sel    = bus.per_en & (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
   assign reg_addr   = {bus.per_addr[DEC_WD-2:0], 1'b0};
   assign rd         = reg_sel & (bus.per_we == 2'b00);
   assign wr_lo      = reg_sel & bus.per_we[0];
   assign sel_status = (reg_addr == DEC_WD'(OFF_STATUS));
   assign sel_data   = (reg_addr == DEC_WD'(OFF_DATA));
   assign sel_ctrl   = (reg_addr == DEC_WD'(OFF_CTRL));

   logic [7:0]       rx_dout;
   logic [RX_CW-1:0] rx_count;
   logic             rx_full;
   logic             rx_empty;
   logic             rx_push;
   logic             rx_pop;
   logic             rx_flush;
   logic [7:0]       tx_dout;
   logic [TX_CW-1:0] tx_count;
   logic             tx_full;
   logic             tx_empty;
   logic             tx_push;
   logic             tx_pop;
   logic             tx_flush;

   assign rx_push  = bus.rx_valid & ~rx_full;
   assign rx_pop   = rd & sel_data & ~rx_empty;
   assign rx_flush = wr_lo & sel_ctrl & bus.per_din[CT_RX_FLUSH];
   // Full is judged on the registered count, so a same-cycle pop never frees room.
   assign tx_push  = wr_lo & sel_data & ~tx_full;
   assign tx_pop   = ~tx_empty & bus.tx_ready;
   assign tx_flush = wr_lo & sel_ctrl & bus.per_din[CT_TX_FLUSH];

   fio_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (mclk),
      .rst   (puc_rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .flush (rx_flush),
      .din   (bus.rx_data),
      .dout  (rx_dout),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   fio_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (mclk),
      .rst   (puc_rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .flush (tx_flush),
      .din   (bus.per_din[7:0]),
      .dout  (tx_dout),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   assign bus.rx_ready = ~rx_full;
   assign bus.tx_valid = ~tx_empty;
   assign bus.tx_data  = tx_dout;

   sticky_t sticky;
   ctrl_t   ctrl;
   logic    rx_unf_set;
   logic    tx_ovf_set;
   logic    st_wr;

   assign rx_unf_set = rd & sel_data & rx_empty;
   assign tx_ovf_set = wr_lo & sel_data & tx_full;
   assign st_wr      = wr_lo & sel_status;

   // A same-cycle error event beats the write-1-to-clear.
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         sticky <= '0;
      end else begin
         if (rx_unf_set)                           sticky.rx_unf <= 1'b1;
         else if (st_wr & bus.per_din[ST_RX_UNF])  sticky.rx_unf <= 1'b0;
         if (tx_ovf_set)                           sticky.tx_ovf <= 1'b1;
         else if (st_wr & bus.per_din[ST_TX_OVF])  sticky.tx_ovf <= 1'b0;
      end
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         ctrl <= '0;
      end else if (wr_lo & sel_ctrl) begin
         ctrl.rx_ie <= bus.per_din[CT_RX_IE];
         ctrl.tx_ie <= bus.per_din[CT_TX_IE];
      end
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) irq <= 1'b0;
      else         irq <= (ctrl.rx_ie & ~rx_empty) | (ctrl.tx_ie & tx_empty);
   end

   always_comb begin
      bus.per_dout = '0;
      if (rd) begin
         if (sel_status)    bus.per_dout = pack_status(8'(rx_count), sticky, ~tx_full, ~rx_empty);
         else if (sel_data) bus.per_dout = {8'h00, rx_dout};
         else if (sel_ctrl) bus.per_dout = {14'b0, ctrl.tx_ie, ctrl.rx_ie};
      end
   end

   logic unused_bits;
   assign unused_bits = &{1'b0, bus.per_din[15:4], tx_count};

endmodule
